victim_cache_control: RTL and testbench

Sequencing controller for the 4-entry fully-associative victim cache. It resolves each L1 miss against the victim entries and performs the hit swap or the miss fill. It also handles dirty-victim writeback to L2 and drives the `load`/`used_way` inputs of the victim-cache LRU unit. It sits between the L1 cache control, the victim-cache tag/data datapath, and the L2 interface, and owns no data storage.

---
 rtl/vc_pkg.sv | 28 ++
 rtl/vc_way_select.sv | 39 +++
 rtl/victim_cache_control.sv | 139 +++++++++++++
 tb/tb_victim_cache_control.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_pkg
// Description : Shared types and constants for the 4-entry victim cache
//               controller and its way-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_pkg;

  // Number of victim entries; tied to the 2-bit way encoding below.
  localparam int VC_WAYS = 4;

  // Victim entry index.
  typedef logic [1:0] vc_way_t;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FETCH     = 3'd3,
    ST_SWAP      = 3'd4,
    ST_FILL      = 3'd5,
    ST_DONE      = 3'd6
  } vc_state_t;

endpackage
`default_nettype wire

// File: rtl/vc_way_select.sv
`default_nettype none
// ============================================================================
// Module      : vc_way_select
// Description : Combinational victim-entry resolution. Produces the qualified
//               hit flag, the lowest-index hit entry and the replacement entry
//               (lowest invalid entry, else the LRU entry).
// Revision    : 1.0 - initial release
// ============================================================================
module vc_way_select
  import vc_pkg::*;
(
  input  logic [VC_WAYS-1:0] tag_hit,
  input  logic [VC_WAYS-1:0] entry_valid,
  input  vc_way_t            lru_way,
  output logic               hit,
  output vc_way_t            hit_way,
  output vc_way_t            repl_way
);

  logic [VC_WAYS-1:0] qual_hit;

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    qual_hit = tag_hit & entry_valid;
    hit      = |qual_hit;
    hit_way  = '0;
    repl_way = lru_way;
    for (int i = VC_WAYS - 1; i >= 0; i--) begin
      if (qual_hit[i]) begin
        hit_way = vc_way_t'(i);
      end
      if (!entry_valid[i]) begin
        repl_way = vc_way_t'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/victim_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : victim_cache_control
// Description : Sequencing controller for the 4-entry fully-associative
//               victim cache: hit swap, miss fill, dirty writeback to L2 and
//               LRU update strobes. All outputs are decoded from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module victim_cache_control
  import vc_pkg::*;
#(
  parameter int WAYS = VC_WAYS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            l1_req,
  input  logic            l1_victim_valid,
  input  logic [WAYS-1:0] tag_hit,
  input  logic [WAYS-1:0] entry_valid,
  input  logic [WAYS-1:0] entry_dirty,
  input  logic [1:0]      lru_way,
  input  logic            l2_resp,
  output logic            l1_resp,
  output logic            vc_hit,
  output logic [1:0]      sel_way,
  output logic            load_entry,
  output logic            inval_entry,
  output logic            l2_read,
  output logic            l2_write,
  output logic            lru_load,
  output logic [1:0]      lru_used_way
);

  vc_state_t state_q, state_d;
  vc_way_t   sel_way_q, sel_way_d;
  logic      hit_q, hit_d;
  // Victim presence is captured at lookup so SWAP/FILL strobes stay Moore.
  logic      victim_q, victim_d;

  logic      ws_hit;
  vc_way_t   ws_hit_way;
  vc_way_t   ws_repl_way;

  vc_way_select u_way_select (
    .tag_hit     (tag_hit),
    .entry_valid (entry_valid),
    .lru_way     (lru_way),
    .hit         (ws_hit),
    .hit_way     (ws_hit_way),
    .repl_way    (ws_repl_way)
  );

  // State and per-transaction registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_way_q <= '0;
      hit_q     <= 1'b0;
      victim_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_way_q <= sel_way_d;
      hit_q     <= hit_d;
      victim_q  <= victim_d;
    end
  end

  // Next-state logic; way/hit/victim are captured in LOOKUP and cleared on return to IDLE.
  always_comb begin
    state_d   = state_q;
    sel_way_d = sel_way_q;
    hit_d     = hit_q;
    victim_d  = victim_q;
    unique case (state_q)
      ST_IDLE: begin
        if (l1_req) begin
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        victim_d = l1_victim_valid;
        if (ws_hit) begin
          sel_way_d = ws_hit_way;
          hit_d     = 1'b1;
          state_d   = ST_SWAP;
        end else begin
          sel_way_d = ws_repl_way;
          hit_d     = 1'b0;
          // Only a valid, dirty entry displaced by an incoming victim needs writeback.
          if (l1_victim_valid && entry_valid[ws_repl_way] && entry_dirty[ws_repl_way]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        if (l2_resp) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (l2_resp) begin
          state_d = ST_FILL;
        end
      end
      ST_SWAP: begin
        state_d = ST_DONE;
      end
      ST_FILL: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        sel_way_d = '0;
        hit_d     = 1'b0;
        victim_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from state and captured registers only.
  always_comb begin
    l1_resp      = (state_q == ST_DONE);
    vc_hit       = (state_q == ST_DONE) && hit_q;
    sel_way      = sel_way_q;
    lru_used_way = sel_way_q;
    l2_write     = (state_q == ST_WRITEBACK);
    l2_read      = (state_q == ST_FETCH);
    load_entry   = ((state_q == ST_SWAP) || (state_q == ST_FILL)) && victim_q;
    inval_entry  = (state_q == ST_SWAP) && !victim_q;
    lru_load     = (state_q == ST_SWAP) || ((state_q == ST_FILL) && victim_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_victim_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_victim_cache_control
// Description : Directed self-checking bench for victim_cache_control.
//               Outputs are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_victim_cache_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       l1_req;
  logic       l1_victim_valid;
  logic [3:0] tag_hit;
  logic [3:0] entry_valid;
  logic [3:0] entry_dirty;
  logic [1:0] lru_way;
  logic       l2_resp;
  logic       l1_resp;
  logic       vc_hit;
  logic [1:0] sel_way;
  logic       load_entry;
  logic       inval_entry;
  logic       l2_read;
  logic       l2_write;
  logic       lru_load;
  logic [1:0] lru_used_way;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  victim_cache_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .l1_req          (l1_req),
    .l1_victim_valid (l1_victim_valid),
    .tag_hit         (tag_hit),
    .entry_valid     (entry_valid),
    .entry_dirty     (entry_dirty),
    .lru_way         (lru_way),
    .l2_resp         (l2_resp),
    .l1_resp         (l1_resp),
    .vc_hit          (vc_hit),
    .sel_way         (sel_way),
    .load_entry      (load_entry),
    .inval_entry     (inval_entry),
    .l2_read         (l2_read),
    .l2_write        (l2_write),
    .lru_load        (lru_load),
    .lru_used_way    (lru_used_way)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares all outputs at once: {l1_resp,vc_hit,sel_way,load,inval,l2_read,l2_write,lru_load,used_way}.
  task automatic chk(input string tag, input logic resp, input logic hit, input logic [1:0] sel,
                     input logic ld, input logic inv, input logic rd, input logic wr, input logic ll);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {l1_resp, vc_hit, sel_way, load_entry, inval_entry, l2_read, l2_write, lru_load, lru_used_way};
    exp = {resp, hit, sel, ld, inv, rd, wr, ll, sel};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (resp,hit,sel,ld,inv,rd,wr,ll,used)", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; l1_req = 1'b0; l1_victim_valid = 1'b0;
    tag_hit = 4'h0; entry_valid = 4'h0; entry_dirty = 4'h0; lru_way = 2'd0; l2_resp = 1'b0;
    #12;
    chk("reset_state", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    step();
    chk("idle_after_reset", 0, 0, 2'd0, 0, 0, 0, 0, 0);

    // Reset while writing back a dirty entry.
    l1_req = 1'b1; l1_victim_valid = 1'b1; tag_hit = 4'h0;
    entry_valid = 4'hF; entry_dirty = 4'b1000; lru_way = 2'd3;
    step(); chk("rstwb_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("rstwb_wb", 0, 0, 2'd3, 0, 0, 0, 1, 0);
    #3 rst_n = 1'b0; l1_req = 1'b0;
    #1 chk("rstwb_async", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step(); chk("rstwb_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("rstwb_stay_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);

    // Hit with victim present: entry 2.
    l1_req = 1'b1; l1_victim_valid = 1'b1; tag_hit = 4'b0100;
    entry_valid = 4'hF; entry_dirty = 4'hF; lru_way = 2'd0;
    step(); chk("hitv_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("hitv_swap", 0, 0, 2'd2, 1, 0, 0, 0, 1);
    step(); chk("hitv_done", 1, 1, 2'd2, 0, 0, 0, 0, 0);
    l1_req = 1'b0;
    step(); chk("hitv_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);

    // Hit without victim: entry 0 invalidated.
    l1_req = 1'b1; l1_victim_valid = 1'b0; tag_hit = 4'b0001; lru_way = 2'd3;
    step(); chk("hitnv_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("hitnv_swap", 0, 0, 2'd0, 0, 1, 0, 0, 1);
    step(); chk("hitnv_done", 1, 1, 2'd0, 0, 0, 0, 0, 0);
    l1_req = 1'b0;
    step(); chk("hitnv_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);

    // Multiple hits resolve to lowest index.
    l1_req = 1'b1; l1_victim_valid = 1'b1; tag_hit = 4'b1010; lru_way = 2'd0;
    step(); chk("multi_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("multi_swap", 0, 0, 2'd1, 1, 0, 0, 0, 1);
    step(); chk("multi_done", 1, 1, 2'd1, 0, 0, 0, 0, 0);
    l1_req = 1'b0;
    step();

    // Miss with invalid entry 2 (its tag match is not qualified); dirty bits irrelevant.
    l1_req = 1'b1; l1_victim_valid = 1'b1; tag_hit = 4'b0100;
    entry_valid = 4'b1011; entry_dirty = 4'hF; lru_way = 2'd0;
    step(); chk("inv_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("inv_fetch1", 0, 0, 2'd2, 0, 0, 1, 0, 0);
    l2_resp = 1'b1;
    step(); chk("inv_fill", 0, 0, 2'd2, 1, 0, 0, 0, 1);
    l2_resp = 1'b0;
    step(); chk("inv_done", 1, 0, 2'd2, 0, 0, 0, 0, 0);
    l1_req = 1'b0;
    step(); chk("inv_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);

    // Clean miss, no victim, all valid: LRU entry 1, minimum latency, no LRU update.
    l1_req = 1'b1; l1_victim_valid = 1'b0; tag_hit = 4'h0;
    entry_valid = 4'hF; entry_dirty = 4'hF; lru_way = 2'd1;
    step(); chk("clean_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    l2_resp = 1'b1;
    chk("clean_fetch", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(); chk("clean_fetch1", 0, 0, 2'd1, 0, 0, 1, 0, 0);
    step(); chk("clean_fill", 0, 0, 2'd1, 0, 0, 0, 0, 0);
    l2_resp = 1'b0;
    step(); chk("clean_done", 1, 0, 2'd1, 0, 0, 0, 0, 0);
    l1_req = 1'b0;
    step();

    // Dirty LRU miss, 3-cycle L2 responses: total latency 9.
    l1_req = 1'b1; l1_victim_valid = 1'b1; tag_hit = 4'h0;
    entry_valid = 4'hF; entry_dirty = 4'b1000; lru_way = 2'd3;
    step(); chk("dirty_c1_lookup", 0, 0, 2'd0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(); chk("dirty_wb", 0, 0, 2'd3, 0, 0, 0, 1, 0);
      if (c == 2) l2_resp = 1'b1;
    end
    step(); l2_resp = 1'b0;
    chk("dirty_fetch_a", 0, 0, 2'd3, 0, 0, 1, 0, 0);
    step(); chk("dirty_fetch_b", 0, 0, 2'd3, 0, 0, 1, 0, 0);
    step(); chk("dirty_fetch_c", 0, 0, 2'd3, 0, 0, 1, 0, 0);
    l2_resp = 1'b1;
    step(); l2_resp = 1'b0;
    chk("dirty_c8_fill", 0, 0, 2'd3, 1, 0, 0, 0, 1);
    step(); chk("dirty_c9_done", 1, 0, 2'd3, 0, 0, 0, 0, 0);
    l1_req = 1'b0;
    step(); chk("dirty_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
